// File: rtl/counter_pkg.sv
// Shared encodings for the up/down counter family: count direction and
// limit behaviour (wrap or hold).
package counter_pkg;
    localparam logic CNT_DN = 1'b0;
    localparam logic CNT_UP = 1'b1;

    localparam int SAT_WRAP = 0;
    localparam int SAT_HOLD = 1;
endpackage

// File: rtl/counter_step.sv
// Combinational next-count for one enabled step: handles the limits and the
// wrap/hold choice, and flags when the step is a limit event.
module counter_step
    import counter_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter int SATURATE = SAT_WRAP
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] max_val,
    input  logic             dir,
    output logic [WIDTH-1:0] nxt,
    output logic             lim_evt
);

    logic [WIDTH-1:0] dec;

    always_comb begin
        nxt     = cnt;
        lim_evt = 1'b0;
        dec     = cnt - WIDTH'(1);
        if (dir == CNT_UP) begin
            // >= rather than == so a count left above a lowered max_val still terminates
            if (cnt >= max_val) begin
                lim_evt = 1'b1;
                nxt     = (SATURATE == SAT_HOLD) ? max_val : '0;
            end else begin
                nxt = cnt + WIDTH'(1);
            end
        end else begin
            if (cnt == '0) begin
                lim_evt = 1'b1;
                nxt     = (SATURATE == SAT_HOLD) ? '0 : max_val;
            end else begin
                nxt = (dec > max_val) ? max_val : dec;
            end
        end
    end

endmodule

// File: rtl/updown_counter.sv
// Programmable-modulus up/down counter with wrap or saturate, a registered
// limit-event pulse and a sticky overflow flag.
module updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter int RST_VAL  = 0,
    parameter int SATURATE = SAT_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             enab,
    input  logic             dir,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] cnt_out,
    output logic             evt,
    output logic             ovf,
    output logic             at_lim
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             evt_q, evt_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] step_nxt;
    logic             step_evt;

    counter_step #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_step (
        .cnt     (cnt_q),
        .max_val (max_val),
        .dir     (dir),
        .nxt     (step_nxt),
        .lim_evt (step_evt)
    );

    // clr > load > enab
    always_comb begin
        cnt_d = cnt_q;
        evt_d = 1'b0;
        ovf_d = ovf_q;
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (load) begin
            cnt_d = (cnt_in > max_val) ? max_val : cnt_in;
            ovf_d = 1'b0;
        end else if (enab) begin
            cnt_d = step_nxt;
            evt_d = step_evt;
            ovf_d = ovf_q | step_evt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= WIDTH'(RST_VAL);
            evt_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            evt_q <= evt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_out = cnt_q;
    assign evt     = evt_q;
    assign ovf     = ovf_q;
    assign at_lim  = (dir == CNT_UP) ? (cnt_q >= max_val) : (cnt_q == '0);

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter: wrap, saturate and RST_VAL=31 instances
// share one set of stimulus inputs.
module tb_updown_counter;

    logic       clk, rst, clr, load, enab, dir;
    logic [4:0] cnt_in, max_val;
    logic [4:0] cnt0, cnt1, cnt2;
    logic       evt0, evt1, evt2, ovf0, ovf1, ovf2, lim0, lim1, lim2;
    int         total = 0;
    int         bad   = 0;

    updown_counter #(.WIDTH(5), .RST_VAL(0), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .enab(enab), .dir(dir),
        .cnt_in(cnt_in), .max_val(max_val),
        .cnt_out(cnt0), .evt(evt0), .ovf(ovf0), .at_lim(lim0));

    updown_counter #(.WIDTH(5), .RST_VAL(0), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .enab(enab), .dir(dir),
        .cnt_in(cnt_in), .max_val(max_val),
        .cnt_out(cnt1), .evt(evt1), .ovf(ovf1), .at_lim(lim1));

    updown_counter #(.WIDTH(5), .RST_VAL(31), .SATURATE(0)) u_mod (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .enab(enab), .dir(dir),
        .cnt_in(cnt_in), .max_val(max_val),
        .cnt_out(cnt2), .evt(evt2), .ovf(ovf2), .at_lim(lim2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick; tick;
        total++; if (cnt0 !== 5'd0)  begin bad++; $display("FAIL reset_cnt0 got=%0d exp=0", cnt0); end
        total++; if (evt0 !== 1'b0)  begin bad++; $display("FAIL reset_evt0 got=%0d exp=0", evt0); end
        total++; if (ovf0 !== 1'b0)  begin bad++; $display("FAIL reset_ovf0 got=%0d exp=0", ovf0); end
        total++; if (cnt2 !== 5'd31) begin bad++; $display("FAIL reset_cnt2 got=%0d exp=31", cnt2); end
        rst = 1'b0; max_val = 5'd9; dir = 1'b1; enab = 1'b1;
        tick; tick; tick;
        total++; if (cnt0 !== 5'd3) begin bad++; $display("FAIL pre_async_cnt got=%0d exp=3", cnt0); end
        // assert rst between edges; outputs must clear before the next edge
        #2 rst = 1'b1;
        #1;
        total++; if (cnt0 !== 5'd0)  begin bad++; $display("FAIL async_rst_cnt0 got=%0d exp=0", cnt0); end
        total++; if (cnt2 !== 5'd31) begin bad++; $display("FAIL async_rst_cnt2 got=%0d exp=31", cnt2); end
        tick;
        total++; if (cnt0 !== 5'd0) begin bad++; $display("FAIL rst_held_cnt0 got=%0d exp=0", cnt0); end
        rst = 1'b0;
    endtask

    task automatic test_up_wrap;
        logic [4:0] ew [12];
        logic [4:0] es [12];
        ew = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd0, 5'd1, 5'd2};
        es = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd9, 5'd9, 5'd9};
        max_val = 5'd9; dir = 1'b1; enab = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick;
            total++; if (cnt0 !== ew[i]) begin bad++; $display("FAIL up_wrap_cnt[%0d] got=%0d exp=%0d", i, cnt0, ew[i]); end
            total++; if (evt0 !== (i == 9)) begin bad++; $display("FAIL up_wrap_evt[%0d] got=%0d exp=%0d", i, evt0, (i == 9)); end
            total++; if (ovf0 !== (i >= 9)) begin bad++; $display("FAIL up_wrap_ovf[%0d] got=%0d exp=%0d", i, ovf0, (i >= 9)); end
            total++; if (cnt1 !== es[i]) begin bad++; $display("FAIL up_sat_cnt[%0d] got=%0d exp=%0d", i, cnt1, es[i]); end
            total++; if (evt1 !== (i >= 9)) begin bad++; $display("FAIL up_sat_evt[%0d] got=%0d exp=%0d", i, evt1, (i >= 9)); end
        end
        total++; if (lim0 !== 1'b0) begin bad++; $display("FAIL up_at_lim0 got=%0d exp=0", lim0); end
        total++; if (lim1 !== 1'b1) begin bad++; $display("FAIL up_at_lim1 got=%0d exp=1", lim1); end
    endtask

    task automatic test_load_down;
        logic [4:0] ew [5];
        logic [4:0] es [5];
        logic       vw [5];
        logic       vs [5];
        ew = '{5'd2, 5'd1, 5'd0, 5'd9, 5'd8};
        es = '{5'd2, 5'd1, 5'd0, 5'd0, 5'd0};
        vw = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        enab = 1'b0; load = 1'b1; cnt_in = 5'd3; dir = 1'b0;
        tick;
        load = 1'b0;
        total++; if (cnt0 !== 5'd3) begin bad++; $display("FAIL load3_cnt0 got=%0d exp=3", cnt0); end
        total++; if (ovf0 !== 1'b0) begin bad++; $display("FAIL load_clr_ovf got=%0d exp=0", ovf0); end
        total++; if (cnt1 !== 5'd3) begin bad++; $display("FAIL load3_cnt1 got=%0d exp=3", cnt1); end
        enab = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            total++; if (cnt0 !== ew[i]) begin bad++; $display("FAIL down_cnt[%0d] got=%0d exp=%0d", i, cnt0, ew[i]); end
            total++; if (evt0 !== vw[i]) begin bad++; $display("FAIL down_evt[%0d] got=%0d exp=%0d", i, evt0, vw[i]); end
            total++; if (cnt1 !== es[i]) begin bad++; $display("FAIL down_sat_cnt[%0d] got=%0d exp=%0d", i, cnt1, es[i]); end
            total++; if (evt1 !== vs[i]) begin bad++; $display("FAIL down_sat_evt[%0d] got=%0d exp=%0d", i, evt1, vs[i]); end
        end
        enab = 1'b0; load = 1'b1; cnt_in = 5'd3;
        tick;
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            total++; if (cnt0 !== 5'd3) begin bad++; $display("FAIL hold_cnt[%0d] got=%0d exp=3", i, cnt0); end
        end
        load = 1'b1; cnt_in = 5'd20;
        tick;
        load = 1'b0;
        total++; if (cnt0 !== 5'd9) begin bad++; $display("FAIL load_clamp got=%0d exp=9", cnt0); end
        total++; if (lim0 !== 1'b0) begin bad++; $display("FAIL down_at_lim got=%0d exp=0", lim0); end
    endtask

    task automatic test_priority;
        dir = 1'b1; enab = 1'b1;
        tick;
        total++; if (ovf0 !== 1'b1) begin bad++; $display("FAIL prio_pre_ovf got=%0d exp=1", ovf0); end
        clr = 1'b1; load = 1'b1; cnt_in = 5'd7;
        tick;
        clr = 1'b0;
        total++; if (cnt0 !== 5'd0) begin bad++; $display("FAIL clr_prio_cnt got=%0d exp=0", cnt0); end
        total++; if (evt0 !== 1'b0) begin bad++; $display("FAIL clr_prio_evt got=%0d exp=0", evt0); end
        total++; if (ovf0 !== 1'b0) begin bad++; $display("FAIL clr_prio_ovf got=%0d exp=0", ovf0); end
        total++; if (cnt1 !== 5'd0) begin bad++; $display("FAIL clr_prio_cnt1 got=%0d exp=0", cnt1); end
        tick;
        load = 1'b0;
        total++; if (cnt0 !== 5'd7) begin bad++; $display("FAIL load_prio_cnt got=%0d exp=7", cnt0); end
        tick; tick; tick;
        total++; if (cnt0 !== 5'd0) begin bad++; $display("FAIL rewrap_cnt got=%0d exp=0", cnt0); end
        total++; if (ovf0 !== 1'b1) begin bad++; $display("FAIL rewrap_ovf got=%0d exp=1", ovf0); end
        load = 1'b1; cnt_in = 5'd4;
        tick;
        load = 1'b0;
        total++; if (cnt0 !== 5'd4) begin bad++; $display("FAIL load4_cnt got=%0d exp=4", cnt0); end
        total++; if (ovf0 !== 1'b0) begin bad++; $display("FAIL load4_ovf got=%0d exp=0", ovf0); end
        total++; if (evt0 !== 1'b0) begin bad++; $display("FAIL load4_evt got=%0d exp=0", evt0); end
        enab = 1'b0;
    endtask

    task automatic test_max_edges;
        max_val = 5'd0; enab = 1'b1;
        for (int d = 1; d >= 0; d--) begin
            dir = d[0];
            for (int i = 0; i < 4; i++) begin
                tick;
                total++; if (cnt0 !== 5'd0) begin bad++; $display("FAIL max0_cnt[d%0d,%0d] got=%0d exp=0", d, i, cnt0); end
                total++; if (evt0 !== 1'b1) begin bad++; $display("FAIL max0_evt[d%0d,%0d] got=%0d exp=1", d, i, evt0); end
                total++; if (cnt1 !== 5'd0) begin bad++; $display("FAIL max0_sat[d%0d,%0d] got=%0d exp=0", d, i, cnt1); end
            end
        end
        total++; if (lim0 !== 1'b1) begin bad++; $display("FAIL max0_at_lim got=%0d exp=1", lim0); end
        // count left above a lowered max_val
        enab = 1'b0; max_val = 5'd31; load = 1'b1; cnt_in = 5'd20;
        tick;
        load = 1'b0; max_val = 5'd5; dir = 1'b1;
        #1;
        total++; if (lim0 !== 1'b1) begin bad++; $display("FAIL lowered_at_lim got=%0d exp=1", lim0); end
        enab = 1'b1;
        tick;
        total++; if (cnt0 !== 5'd0) begin bad++; $display("FAIL lowered_up_cnt got=%0d exp=0", cnt0); end
        total++; if (evt0 !== 1'b1) begin bad++; $display("FAIL lowered_up_evt got=%0d exp=1", evt0); end
        total++; if (cnt1 !== 5'd5) begin bad++; $display("FAIL lowered_up_sat got=%0d exp=5", cnt1); end
        enab = 1'b0; max_val = 5'd31; load = 1'b1; cnt_in = 5'd20;
        tick;
        load = 1'b0; max_val = 5'd5; dir = 1'b0; enab = 1'b1;
        tick;
        total++; if (cnt0 !== 5'd5) begin bad++; $display("FAIL lowered_dn_cnt got=%0d exp=5", cnt0); end
        total++; if (evt0 !== 1'b0) begin bad++; $display("FAIL lowered_dn_evt got=%0d exp=0", evt0); end
        total++; if (cnt1 !== 5'd5) begin bad++; $display("FAIL lowered_dn_sat got=%0d exp=5", cnt1); end
        enab = 1'b0;
    endtask

    task automatic test_modulo;
        int         nevt;
        logic [4:0] e;
        nevt = 0;
        rst = 1'b1; max_val = 5'd31; dir = 1'b1; enab = 1'b1;
        tick;
        rst = 1'b0;
        total++; if (cnt2 !== 5'd31) begin bad++; $display("FAIL mod_start got=%0d exp=31", cnt2); end
        for (int i = 1; i <= 33; i++) begin
            tick;
            e = 5'(i - 1);
            if (evt2) nevt++;
            total++; if (cnt2 !== e) begin bad++; $display("FAIL mod_cnt[%0d] got=%0d exp=%0d", i, cnt2, e); end
            total++; if (evt2 !== (i == 1 || i == 33)) begin bad++; $display("FAIL mod_evt[%0d] got=%0d exp=%0d", i, evt2, (i == 1 || i == 33)); end
        end
        total++; if (nevt != 2) begin bad++; $display("FAIL mod_evt_count got=%0d exp=2", nevt); end
        enab = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; load = 1'b0; enab = 1'b0; dir = 1'b1;
        cnt_in = 5'd0; max_val = 5'd0;
        test_reset;
        test_up_wrap;
        test_load_down;
        test_priority;
        test_max_edges;
        test_modulo;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
